abs_bin_acc: RTL and testbench
==============================

# abs_bin_acc

Windowed accumulator that converts the sign/magnitude bitstream pair from the bipolar absolute-value stage into a binary result. It counts `abs` ones and `sign` ones over a fixed window of 2^WIDTH valid cycles. At each window boundary it emits the unsigned magnitude and a majority-vote sign through a valid/ready output register. It sits directly downstream of the absolute-value kernel and serves as the stochastic-to-binary exit point for result capture and checking.

## Interface
- WIDTH, 8: log2 of the window length, so the window is 2^WIDTH valid input cycles; WIDTH >= 2.
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- in_valid  input  1  `sign` and `abs` are valid this cycle.
- sign  input  1  sign bit from the abs stage (1 = negative).
- abs  input  1  unipolar magnitude bitstream bit from the abs stage.
- clr  input  1  synchronous clear; abandons the current window.
- out_ready  input  1  consumer accepts `out_*` this cycle.
- out_valid  output  1  result register holds an unconsumed result.
- out_mag  output  WIDTH+1  number of `abs` ones in the window, range 0..2^WIDTH.
- out_sign  output  1  1 iff `sign` ones in the window > 2^(WIDTH-1); a tie gives 0.
- out_ovf  output  1  sticky; a result was overwritten before it was consumed.

## Operation
- Internal state:
  - wcnt[WIDTH-1:0]: window position.
  - mcnt[WIDTH:0]: count of `abs` ones.
  - scnt[WIDTH:0]: count of `sign` ones.
- Priority each cycle: rst_n low > clr > normal operation.
- Reset (rst_n = 0 at an edge): wcnt, mcnt, scnt, out_mag = 0; out_sign, out_valid, out_ovf = 0. This applies mid-window too; the partial window is discarded.
- clr = 1: wcnt, mcnt, scnt, out_valid and out_ovf cleared. out_mag and out_sign keep their values. The in_valid sample in the same cycle is dropped.
- in_valid = 0: counters hold; gaps of any length are allowed inside a window.
- in_valid = 1 and wcnt != 2^WIDTH-1:
  - wcnt += 1.
  - mcnt += abs.
  - scnt += sign.
- in_valid = 1 and wcnt == 2^WIDTH-1 (window end):
  - out_mag <= mcnt + abs.
  - out_sign <= (scnt + sign) > 2^(WIDTH-1).
  - out_valid <= 1.
  - wcnt, mcnt, scnt <= 0.
  - The next valid sample starts the new window; there are no dead cycles between windows.
- Output handshake:
  - A transfer occurs when out_valid & out_ready.
  - out_valid falls after a transfer unless a window end occurs in the same cycle.
- Window end with out_valid = 1 and out_ready = 0: the result register is overwritten and out_ovf <= 1. out_ovf stays 1 until clr or reset.
- Window end with out_valid = 1 and out_ready = 1: the old result transfers, the new one loads, out_valid stays 1, and out_ovf is unchanged.
- Counter widths: WIDTH+1 bits are sufficient; no saturation is needed because the counts are bounded by the window.

## Timing
- Latency: the result is visible (out_valid = 1) on the cycle after the edge that samples the last valid bit of the window.
- Throughput: one result per 2^WIDTH valid samples; the input is never back-pressured.
- out_mag, out_sign and out_valid are registered outputs; there is no combinational path from any input to any output.
- out_mag and out_sign are stable while out_valid = 1 and no new window end occurs.
- Reset and clr take effect on the edge where they are sampled; outputs show cleared values the following cycle.

## Test plan
- Full-scale magnitude (WIDTH = 4): 16 consecutive valid cycles with abs = 1 and sign = 0, out_ready = 1 → one-cycle out_valid pulse with out_mag = 16 and out_sign = 0.
- Sign majority boundary (WIDTH = 4):
  - Window with 8 sign ones and abs = 1 in 5 of the 16 cycles → out_mag = 5, out_sign = 0.
  - Next window with 9 sign ones → out_sign = 1.
- Gapped input: 16 valid samples interleaved with random in_valid = 0 cycles, abs pattern 1010… → out_mag = 8. out_valid asserts exactly one cycle after the 16th valid sample.
- Back-pressure / overflow: out_ready = 0 for two full windows with abs counts 3 then 11 → out_mag = 11, out_valid = 1, out_ovf = 1. A subsequent out_ready pulse drops out_valid while out_ovf stays 1.
- Simultaneous accept and complete: out_ready = 1 on the exact cycle the second window ends → out_valid stays high, out_mag updates to the second window's value, out_ovf = 0.
- clr and reset mid-window:
  - clr asserted after 7 valid samples → no output; the next 16 samples (all abs = 1) give out_mag = 16.
  - rst_n low mid-window → all outputs 0 on the next cycle, and counting restarts from zero.

Source files
------------

// File: rtl/abs_bin_acc_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : abs_bin_acc_if                                                |
// | Purpose  : Bundles the sample input stream and the valid/ready result    |
// |            port of the windowed sign/magnitude accumulator.              |
// | Ports    : in_valid, sign, abs, clr    - sample stream + clear           |
// |            out_ready                   - consumer accept                 |
// |            out_valid, out_mag,                                           |
// |            out_sign, out_ovf           - registered result               |
// | Modports : master - producer/consumer side (drives inputs)               |
// |            slave  - accumulator side (drives results)                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface abs_bin_acc_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             sign;
   logic             abs;
   logic             clr;
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH:0]   out_mag;
   logic             out_sign;
   logic             out_ovf;

   modport master (
      output in_valid, sign, abs, clr, out_ready,
      input  out_valid, out_mag, out_sign, out_ovf
   );

   modport slave (
      input  in_valid, sign, abs, clr, out_ready,
      output out_valid, out_mag, out_sign, out_ovf
   );
endinterface
`default_nettype wire

// File: rtl/abs_bin_acc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : abs_bin_acc                                                   |
// | Purpose  : Stochastic-to-binary exit point. Counts abs ones and sign     |
// |            ones over a window of 2^WIDTH valid samples and, at each      |
// |            window end, loads the magnitude and a majority-vote sign into |
// |            a valid/ready result register.                                |
// | Ports    : clk   - rising-edge clock                                     |
// |            rst_n - synchronous active-low reset                          |
// |            bus   - abs_bin_acc_if.slave (samples, clr, result handshake) |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module abs_bin_acc #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   abs_bin_acc_if.slave       bus
);

   localparam logic [WIDTH-1:0] WLAST = {WIDTH{1'b1}};
   // Sign majority threshold: strictly more than half the window.
   localparam logic [WIDTH:0]   HALF  = (WIDTH+1)'(1) << (WIDTH-1);

   logic [WIDTH-1:0] wcnt;
   logic [WIDTH:0]   mcnt;
   logic [WIDTH:0]   scnt;
   logic [WIDTH:0]   mag_q;
   logic             sign_q;
   logic             valid_q;
   logic             ovf_q;

   logic             win_end;
   logic [WIDTH:0]   mcnt_inc;
   logic [WIDTH:0]   scnt_inc;
   logic             xfer;

   // Counts including the current sample; at window end these are the final
   // totals and can reach 2^WIDTH, which the extra counter bit holds.
   assign mcnt_inc = mcnt + (WIDTH+1)'(bus.abs);
   assign scnt_inc = scnt + (WIDTH+1)'(bus.sign);
   assign win_end  = bus.in_valid && (wcnt == WLAST);
   assign xfer     = valid_q && bus.out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wcnt    <= '0;
         mcnt    <= '0;
         scnt    <= '0;
         mag_q   <= '0;
         sign_q  <= 1'b0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (bus.clr) begin
         // Result value is deliberately retained; only its validity goes.
         wcnt    <= '0;
         mcnt    <= '0;
         scnt    <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (win_end) begin
            mag_q   <= mcnt_inc;
            sign_q  <= (scnt_inc > HALF);
            valid_q <= 1'b1;
            wcnt    <= '0;
            mcnt    <= '0;
            scnt    <= '0;
            // Overwriting a result nobody is taking this cycle loses it.
            if (valid_q && !bus.out_ready) begin
               ovf_q <= 1'b1;
            end
         end else begin
            if (bus.in_valid) begin
               wcnt <= wcnt + 1'b1;
               mcnt <= mcnt_inc;
               scnt <= scnt_inc;
            end
            if (xfer) begin
               valid_q <= 1'b0;
            end
         end
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.out_mag   = mag_q;
   assign bus.out_sign  = sign_q;
   assign bus.out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_abs_bin_acc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_abs_bin_acc                                                |
// | Purpose  : Directed scoreboard bench for abs_bin_acc with WIDTH = 4.     |
// |            Stimulus pushes the expected result of every transfer; a      |
// |            negedge monitor pops and compares on each out_valid&out_ready.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_abs_bin_acc;

   localparam int W = 4;
   localparam int N = 1 << W;

   typedef struct packed {
      logic [W:0] mag;
      logic       sgn;
      logic       ovf;
   } exp_t;

   logic clk;
   logic rst_n;
   int   applied;
   int   miscompares;
   exp_t q[$];

   abs_bin_acc_if #(.WIDTH(W)) bus ();

   abs_bin_acc #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: a transfer happens at the next rising edge when both are high.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         exp_t got;
         exp_t e;
         got = {bus.out_mag, bus.out_sign, bus.out_ovf};
         applied = applied + 1;
         if (q.size() == 0) begin
            miscompares = miscompares + 1;
            $display("FAIL unexpected_result got mag=%0d sign=%0d ovf=%0d required none",
                     got.mag, got.sgn, got.ovf);
         end else begin
            e = q.pop_front();
            if (got !== e) begin
               miscompares = miscompares + 1;
               $display("FAIL result got mag=%0d sign=%0d ovf=%0d required mag=%0d sign=%0d ovf=%0d",
                        got.mag, got.sgn, got.ovf, e.mag, e.sgn, e.ovf);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      applied = applied + 1;
      if (act !== req) begin
         miscompares = miscompares + 1;
         $display("FAIL %s got %0d required %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic s, input logic a);
      bus.in_valid = 1'b1;
      bus.sign     = s;
      bus.abs      = a;
      tick();
      bus.in_valid = 1'b0;
      bus.sign     = 1'b0;
      bus.abs      = 1'b0;
   endtask

   task automatic push(input int mag, input logic s, input logic o);
      exp_t e;
      e.mag = (W+1)'(mag);
      e.sgn = s;
      e.ovf = o;
      q.push_back(e);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, int'(bus.out_valid), 0);
      chk({tag, "_mag"},   int'(bus.out_mag),   0);
      chk({tag, "_sign"},  int'(bus.out_sign),  0);
      chk({tag, "_ovf"},   int'(bus.out_ovf),   0);
   endtask

   initial begin
      applied      = 0;
      miscompares  = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.sign     = 1'b0;
      bus.abs      = 1'b0;
      bus.clr      = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      chk_zero("reset");

      // Full-scale magnitude, one-cycle valid pulse.
      bus.out_ready = 1'b1;
      push(16, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) begin
         if (i == N - 1) chk("full_pre_valid", int'(bus.out_valid), 0);
         send(1'b0, 1'b1);
      end
      chk("full_valid", int'(bus.out_valid), 1);
      tick();
      chk("full_pulse_end", int'(bus.out_valid), 0);

      // Sign majority: 8 ones is a tie (0), 9 ones is a majority (1).
      push(5, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) send(i < 8, (i % 3) == 0 && i < 13);
      chk("tie_valid", int'(bus.out_valid), 1);
      push(10, 1'b1, 1'b0);
      for (int i = 0; i < N; i++) send(i < 9, i < 10);
      chk("maj_valid", int'(bus.out_valid), 1);
      tick();

      // Gapped input, abs = 1010...
      push(8, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) begin
         int gap;
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) tick();
         if (i == N - 1) chk("gap_pre_valid", int'(bus.out_valid), 0);
         send(1'b0, (i % 2) == 0);
      end
      chk("gap_valid", int'(bus.out_valid), 1);
      tick();
      chk("gap_pulse_end", int'(bus.out_valid), 0);

      // Back-pressure: two windows unconsumed, abs counts 3 then 11.
      bus.out_ready = 1'b0;
      for (int i = 0; i < N; i++) send(1'b0, i < 3);
      chk("bp1_valid", int'(bus.out_valid), 1);
      chk("bp1_mag",   int'(bus.out_mag),   3);
      chk("bp1_ovf",   int'(bus.out_ovf),   0);
      for (int i = 0; i < N; i++) send(i < 12, i < 11);
      chk("bp2_valid", int'(bus.out_valid), 1);
      chk("bp2_mag",   int'(bus.out_mag),   11);
      chk("bp2_ovf",   int'(bus.out_ovf),   1);
      push(11, 1'b1, 1'b1);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("bp_drain_valid", int'(bus.out_valid), 0);
      chk("bp_sticky_ovf",  int'(bus.out_ovf),   1);

      // clr drops validity and overflow but keeps the result value.
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      chk("clr_ovf",   int'(bus.out_ovf),   0);
      chk("clr_valid", int'(bus.out_valid), 0);
      chk("clr_mag",   int'(bus.out_mag),   11);
      chk("clr_sign",  int'(bus.out_sign),  1);

      // Accept and complete in the same cycle.
      for (int i = 0; i < N; i++) send(1'b0, i < 4);
      chk("sim1_valid", int'(bus.out_valid), 1);
      push(4, 1'b0, 1'b0);
      push(13, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) begin
         if (i == N - 1) bus.out_ready = 1'b1;
         send(1'b0, i < 13);
      end
      chk("sim_valid_held", int'(bus.out_valid), 1);
      chk("sim_mag",        int'(bus.out_mag),   13);
      chk("sim_ovf",        int'(bus.out_ovf),   0);
      tick();
      chk("sim_drain_valid", int'(bus.out_valid), 0);

      // clr mid-window; the sample presented alongside clr is dropped.
      for (int i = 0; i < 7; i++) send(1'b1, 1'b1);
      bus.clr      = 1'b1;
      bus.in_valid = 1'b1;
      bus.sign     = 1'b1;
      bus.abs      = 1'b1;
      tick();
      bus.clr      = 1'b0;
      bus.in_valid = 1'b0;
      bus.sign     = 1'b0;
      bus.abs      = 1'b0;
      chk("clrmid_valid", int'(bus.out_valid), 0);
      push(16, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) begin
         if (i == N - 1) chk("clrmid_pre_valid", int'(bus.out_valid), 0);
         send(1'b0, 1'b1);
      end
      chk("clrmid_valid_end", int'(bus.out_valid), 1);
      tick();

      // Reset mid-window clears everything, counting restarts from zero.
      for (int i = 0; i < 5; i++) send(1'b1, 1'b1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_zero("rstmid");
      push(16, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) begin
         if (i == N - 1) chk("rstmid_pre_valid", int'(bus.out_valid), 0);
         send(1'b0, 1'b1);
      end
      chk("rstmid_valid_end", int'(bus.out_valid), 1);
      tick();
      tick();

      chk("scoreboard_empty", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
